// File: rtl/icache_ctrl_if.sv
// Fetch-port and memory-port signals of the instruction cache.
// The slave side is the cache; the master side is the fetch stage plus memory.
interface icache_ctrl_if #(
  parameter int unsigned TAG_BITS = 11
) ();
  logic                fetch_req;
  logic [15:0]         fetch_addr;
  logic                flush;
  logic [15:0]         instr;
  logic                instr_valid;
  logic                stall;
  logic                hit;
  logic [TAG_BITS-1:0] tag_out;
  logic                mem_rd_req;
  logic [15:0]         mem_addr;
  logic [15:0]         mem_rd_data;
  logic                mem_rd_valid;
  logic [15:0]         miss_cnt;

  modport master (
    output fetch_req, fetch_addr, flush, mem_rd_data, mem_rd_valid,
    input  instr, instr_valid, stall, hit, tag_out, mem_rd_req, mem_addr, miss_cnt
  );

  modport slave (
    input  fetch_req, fetch_addr, flush, mem_rd_data, mem_rd_valid,
    output instr, instr_valid, stall, hit, tag_out, mem_rd_req, mem_addr, miss_cnt
  );
endinterface

// File: rtl/icache_ctrl.sv
// Direct-mapped read-only instruction cache with a word-by-word line-fill FSM.
// Hits answer combinationally; misses stall fetch until the line is filled.
module icache_ctrl #(
  parameter int unsigned INDEX_BITS  = 3,
  parameter int unsigned OFFSET_BITS = 2
) (
  input  logic          clk,
  input  logic          rst,
  icache_ctrl_if.slave  bus
);
  localparam int unsigned TAG_BITS = 16 - INDEX_BITS - OFFSET_BITS;
  localparam int unsigned LINES    = 1 << INDEX_BITS;
  localparam int unsigned WORDS    = 1 << OFFSET_BITS;

  typedef enum logic [1:0] {IDLE, FILL, RESUME} state_e;

  state_e                 state_q, state_d;
  logic [OFFSET_BITS-1:0] cnt_q, cnt_d, cnt_inc;
  logic [TAG_BITS-1:0]    miss_tag_q, miss_tag_d;
  logic [INDEX_BITS-1:0]  miss_idx_q, miss_idx_d;
  logic [15:0]            miss_cnt_q, miss_cnt_d;
  logic                   mem_rd_req_q, mem_rd_req_d;
  logic [15:0]            mem_addr_q, mem_addr_d;
  logic                   flush_pend_q, flush_pend_d;
  logic [LINES-1:0]       valid_q, valid_d;
  logic [TAG_BITS-1:0]    tag_q  [LINES];
  logic [15:0]            data_q [LINES*WORDS];
  logic                   data_we, tag_we;

  logic [INDEX_BITS-1:0]  idx;
  logic [OFFSET_BITS-1:0] off;
  logic [TAG_BITS-1:0]    tag;
  logic                   hit_c;

  // Lookup path: purely combinational from storage and fetch_addr
  assign off   = bus.fetch_addr[OFFSET_BITS-1:0];
  assign idx   = bus.fetch_addr[OFFSET_BITS +: INDEX_BITS];
  assign tag   = bus.fetch_addr[15 -: TAG_BITS];
  assign hit_c = bus.fetch_req && valid_q[idx] && (tag_q[idx] == tag);

  assign bus.hit         = hit_c;
  assign bus.tag_out     = tag_q[idx];
  assign bus.instr_valid = (state_q == IDLE) && hit_c;
  assign bus.instr       = ((state_q == IDLE) && hit_c) ? data_q[{idx, off}] : 16'h0000;
  assign bus.stall       = (state_q != IDLE) || (bus.fetch_req && !hit_c);
  assign bus.mem_rd_req  = mem_rd_req_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.miss_cnt    = miss_cnt_q;

  assign cnt_inc = cnt_q + OFFSET_BITS'(1);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    miss_tag_d   = miss_tag_q;
    miss_idx_d   = miss_idx_q;
    miss_cnt_d   = miss_cnt_q;
    mem_rd_req_d = mem_rd_req_q;
    mem_addr_d   = mem_addr_q;
    flush_pend_d = flush_pend_q;
    valid_d      = valid_q;
    data_we      = 1'b0;
    tag_we       = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.fetch_req && !hit_c) begin
          state_d      = FILL;
          cnt_d        = '0;
          miss_tag_d   = tag;
          miss_idx_d   = idx;
          miss_cnt_d   = (miss_cnt_q == 16'hFFFF) ? miss_cnt_q : miss_cnt_q + 16'd1;
          mem_rd_req_d = 1'b1;
          mem_addr_d   = {tag, idx, {OFFSET_BITS{1'b0}}};
        end
        if (bus.flush) valid_d = '0;
      end
      FILL: begin
        if (bus.flush) flush_pend_d = 1'b1;
        if (bus.mem_rd_valid && mem_rd_req_q) begin
          data_we = 1'b1;
          if (cnt_q == OFFSET_BITS'(WORDS - 1)) begin
            tag_we              = 1'b1;
            valid_d[miss_idx_q] = 1'b1;
            mem_rd_req_d        = 1'b0;
            state_d             = RESUME;
          end else begin
            cnt_d      = cnt_inc;
            mem_addr_d = {miss_tag_q, miss_idx_q, cnt_inc};
          end
        end
      end
      RESUME: begin
        // A flush seen during the fill lands here, wiping the fresh line too
        state_d      = IDLE;
        flush_pend_d = 1'b0;
        if (flush_pend_q || bus.flush) valid_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      miss_tag_q   <= '0;
      miss_idx_q   <= '0;
      miss_cnt_q   <= '0;
      mem_rd_req_q <= 1'b0;
      mem_addr_q   <= '0;
      flush_pend_q <= 1'b0;
      valid_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      miss_tag_q   <= miss_tag_d;
      miss_idx_q   <= miss_idx_d;
      miss_cnt_q   <= miss_cnt_d;
      mem_rd_req_q <= mem_rd_req_d;
      mem_addr_q   <= mem_addr_d;
      flush_pend_q <= flush_pend_d;
      valid_q      <= valid_d;
    end
  end

  // Data and tag arrays are not reset; writes are suppressed during reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (data_we) data_q[{miss_idx_q, cnt_q}] <= bus.mem_rd_data;
      if (tag_we)  tag_q[miss_idx_q]           <= miss_tag_q;
    end
  end
endmodule
